// File: rtl/prog_loader.sv
// Program-load controller: streams program words into instruction memory and
// holds the CPU out of run until a load session completes.
//
// Ports:
//   clk, reset (async, active-low)
//   prog_en            - level request to start/hold a load session
//   burst              - auto-increment mode, sampled on a session's first beat
//   in_valid/in_ready  - beat handshake; in_addr, in_data, in_last carry the beat
//   w_en/w_addr/w_data - registered instruction-memory write port
//   cpu_run            - processor may execute
//   done               - one-cycle pulse at session end
//   checksum           - mod-2^DW sum of words written this session
//   word_count         - words written this session, saturating
//   err                - sticky out-of-range address flag for this session
module prog_loader #(
    parameter int unsigned AW        = 12,
    parameter int unsigned DW        = 16,
    parameter int unsigned MEM_DEPTH = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_en,
    input  logic          burst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          w_en,
    output logic [AW-1:0] w_addr,
    output logic [DW-1:0] w_data,
    output logic          cpu_run,
    output logic          done,
    output logic [DW-1:0] checksum,
    output logic [AW:0]   word_count,
    output logic          err
);

    // One extra address bit so a burst can run past the top without wrapping.
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        RUN
    } state_t;

    state_t          state;
    logic            first_beat;
    logic            burst_mode;
    logic [CW-1:0]   prev_addr;

    logic            accept_c;
    logic            enter_load_c;
    logic [CW-1:0]   next_addr_c;
    logic [CW-1:0]   beat_addr_c;
    logic            addr_ok_c;

    // Beat address resolution and range check.
    always_comb begin
        accept_c     = in_valid & in_ready;
        enter_load_c = ((state == IDLE) || (state == RUN)) && prog_en;
        // Saturating at all-ones keeps a runaway burst out of range forever.
        next_addr_c  = (prev_addr == '1) ? prev_addr : prev_addr + CW'(1);
        beat_addr_c  = (first_beat || !burst_mode) ? {1'b0, in_addr} : next_addr_c;
        addr_ok_c    = beat_addr_c < DEPTH;
    end

    // Session FSM with registered state decodes and write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            first_beat <= 1'b0;
            burst_mode <= 1'b0;
            prev_addr  <= '0;
            in_ready   <= 1'b0;
            w_en       <= 1'b0;
            w_addr     <= '0;
            w_data     <= '0;
            cpu_run    <= 1'b0;
            done       <= 1'b0;
            checksum   <= '0;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            w_en <= 1'b0;
            done <= 1'b0;

            if (enter_load_c) begin
                checksum   <= '0;
                word_count <= '0;
                err        <= 1'b0;
                first_beat <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (prog_en) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end else begin
                        state   <= RUN;
                        cpu_run <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept_c) begin
                        first_beat <= 1'b0;
                        prev_addr  <= beat_addr_c;
                        if (first_beat) begin
                            burst_mode <= burst;
                        end
                        if (addr_ok_c) begin
                            w_en     <= 1'b1;
                            w_addr   <= beat_addr_c[AW-1:0];
                            w_data   <= in_data;
                            checksum <= checksum + in_data;
                            if (word_count != '1) begin
                                word_count <= word_count + CW'(1);
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    if ((accept_c && in_last) || !prog_en) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= RUN;
                    cpu_run <= 1'b1;
                end
                RUN: begin
                    if (prog_en) begin
                        state    <= LOAD;
                        cpu_run  <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    cpu_run  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: cycle-level vector table plus
// hand-written reset sequences.
module tb_prog_loader;

    logic        clk;
    logic        reset;
    logic        prog_en;
    logic        burst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_addr;
    logic [15:0] in_data;
    logic        in_last;
    logic        w_en;
    logic [11:0] w_addr;
    logic [15:0] w_data;
    logic        cpu_run;
    logic        done;
    logic [15:0] checksum;
    logic [12:0] word_count;
    logic        err;

    int checks;
    int errors;

    prog_loader #(.AW(12), .DW(16), .MEM_DEPTH(4096)) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_en    (prog_en),
        .burst      (burst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .in_last    (in_last),
        .w_en       (w_en),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .cpu_run    (cpu_run),
        .done       (done),
        .checksum   (checksum),
        .word_count (word_count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied before an edge, outputs expected just after it.
    typedef struct {
        logic        pe;
        logic        bu;
        logic        iv;
        logic [11:0] ad;
        logic [15:0] da;
        logic        la;
        logic        e_rdy;
        logic        e_wen;
        logic [11:0] e_waddr;
        logic [15:0] e_wdata;
        logic        e_done;
        logic        e_run;
        logic        st;
        logic [15:0] e_chk;
        logic [12:0] e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int pe, input int bu, input int iv, input int ad,
                       input int da, input int la, input int er, input int ew,
                       input int ea, input int ed, input int edn, input int erun,
                       input int st, input int ec, input int en, input int ee);
        vec_t v;
        v.pe = 1'(pe);      v.bu = 1'(bu);      v.iv = 1'(iv);
        v.ad = 12'(ad);     v.da = 16'(da);     v.la = 1'(la);
        v.e_rdy = 1'(er);   v.e_wen = 1'(ew);   v.e_waddr = 12'(ea);
        v.e_wdata = 16'(ed); v.e_done = 1'(edn); v.e_run = 1'(erun);
        v.st = 1'(st);      v.e_chk = 16'(ec);  v.e_cnt = 13'(en);
        v.e_err = 1'(ee);
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " in_ready"},   32'(in_ready),   32'd0);
        chk({tag, " w_en"},       32'(w_en),       32'd0);
        chk({tag, " w_addr"},     32'(w_addr),     32'd0);
        chk({tag, " w_data"},     32'(w_data),     32'd0);
        chk({tag, " cpu_run"},    32'(cpu_run),    32'd0);
        chk({tag, " done"},       32'(done),       32'd0);
        chk({tag, " checksum"},   32'(checksum),   32'd0);
        chk({tag, " word_count"}, 32'(word_count), 32'd0);
        chk({tag, " err"},        32'(err),        32'd0);
    endtask

    int d1[11] = '{'h7400, 'h7300, 'h7800, 'h7900, 'h1103, 'h7100,
                   'h7700, 'h7100, 'h7D00, 'h4006, 'hF400};

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        prog_en  = 1'b1;
        burst    = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        in_last  = 1'b0;

        // Session 1: single mode, 11 beats with one idle gap.
        add(1,0,0,0,0,0,     1,0,0,0,0,0,  1,0,0,0);
        for (int i = 0; i < 11; i++) begin
            if (i == 5) add(1,0,0,0,0,0, 1,0,0,0,0,0, 0,0,0,0);
            add(1,0,1,i,d1[i],(i == 10) ? 1 : 0,
                (i != 10) ? 1 : 0, 1, i, d1[i], (i == 10) ? 1 : 0, 0,
                (i == 10) ? 1 : 0, 'hF309, 11, 0);
        end
        add(0,0,0,0,0,0,     0,0,0,0,0,1,  1,'hF309,11,0);

        // Session 2: burst from 0x100; later in_addr and burst inputs ignored.
        add(1,0,0,0,0,0,     1,0,0,0,0,0,  1,0,0,0);
        add(1,1,1,'h100,3,0, 1,1,'h100,3,0,0, 0,0,0,0);
        add(1,0,1,'h555,1,0, 1,1,'h101,1,0,0, 0,0,0,0);
        add(1,0,1,'h000,2,0, 1,1,'h102,2,0,0, 0,0,0,0);
        add(1,1,1,'h007,3,1, 0,1,'h103,3,1,0, 1,9,4,0);
        add(0,0,0,0,0,0,     0,0,0,0,0,1,  1,9,4,0);

        // Session 3: burst crosses the top of memory.
        add(1,0,0,0,0,0,     1,0,0,0,0,0,  1,0,0,0);
        add(1,1,1,'hFFE,'hA,0, 1,1,'hFFE,'hA,0,0, 0,0,0,0);
        add(1,1,1,0,'hB,0,   1,1,'hFFF,'hB,0,0, 1,'h15,2,0);
        add(1,1,1,0,'hC,0,   1,0,0,0,0,0,  1,'h15,2,1);
        add(1,1,1,0,'hD,1,   0,0,0,0,1,0,  1,'h15,2,1);

        // RUN with in_valid held high: nothing written, results held.
        for (int i = 0; i < 3; i++) add(0,0,1,'h20,'h77,0, 0,0,0,0,0,1, 1,'h15,2,1);
        // Re-entry edge: beat not accepted, session results cleared.
        add(1,0,1,'h20,'h77,0, 1,0,0,0,0,0, 1,0,0,0);

        // Session 4: prog_en dropped while a beat is accepted.
        add(1,0,1,5,'h1234,0, 1,1,5,'h1234,0,0, 1,'h1234,1,0);
        add(0,0,1,6,'h5678,0, 0,1,6,'h5678,1,0, 1,'h68AC,2,0);
        add(0,0,1,7,'h9999,0, 0,0,0,0,0,1,     1,'h68AC,2,0);
        add(0,0,1,8,'h9999,0, 0,0,0,0,0,1,     1,'h68AC,2,0);

        #12;
        chk_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            prog_en  = vq[i].pe;
            burst    = vq[i].bu;
            in_valid = vq[i].iv;
            in_addr  = vq[i].ad;
            in_data  = vq[i].da;
            in_last  = vq[i].la;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vq[i].e_rdy));
            chk($sformatf("v%0d w_en", i),     32'(w_en),     32'(vq[i].e_wen));
            chk($sformatf("v%0d done", i),     32'(done),     32'(vq[i].e_done));
            chk($sformatf("v%0d cpu_run", i),  32'(cpu_run),  32'(vq[i].e_run));
            if (vq[i].e_wen) begin
                chk($sformatf("v%0d w_addr", i), 32'(w_addr), 32'(vq[i].e_waddr));
                chk($sformatf("v%0d w_data", i), 32'(w_data), 32'(vq[i].e_wdata));
            end
            if (vq[i].st) begin
                chk($sformatf("v%0d checksum", i),   32'(checksum),   32'(vq[i].e_chk));
                chk($sformatf("v%0d word_count", i), 32'(word_count), 32'(vq[i].e_cnt));
                chk($sformatf("v%0d err", i),        32'(err),        32'(vq[i].e_err));
            end
            @(negedge clk);
        end

        // Reset asserted in the middle of a burst.
        prog_en  = 1'b1;
        burst    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        chk("mid in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = 12'h010;
        in_data  = 16'h0001;
        @(posedge clk);
        #1;
        chk("mid w_en", 32'(w_en), 32'd1);
        @(negedge clk);
        in_data = 16'h0002;
        @(posedge clk);
        #1;
        chk("mid w_addr", 32'(w_addr), 32'h011);
        reset = 1'b0;
        #1;
        chk_reset_vals("async");
        @(negedge clk);
        prog_en  = 1'b0;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        chk("post cpu_run",    32'(cpu_run),    32'd1);
        chk("post in_ready",   32'(in_ready),   32'd0);
        chk("post checksum",   32'(checksum),   32'd0);
        chk("post word_count", 32'(word_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
